// File: rtl/palette_commit_scheduler.sv
// Arbitrates palette RAM port B between immediate reads and a FIFO of queued
// writes that are committed only while the drain gate (vblank or commit_anytime) is open.
module palette_commit_scheduler #(
  parameter int COLOR_COUNT = 256,
  parameter int COLOR_BITS  = 12,
  parameter int FIFO_DEPTH  = 16,
  localparam int COLOR_BYTES = (COLOR_BITS - 1) / 8 + 1,
  localparam int CAPACITY    = COLOR_BYTES * COLOR_COUNT,
  localparam int AW          = $clog2(CAPACITY),
  localparam int CW          = $clog2(FIFO_DEPTH + 1),
  localparam int PW          = $clog2(FIFO_DEPTH)
) (
  input  logic          vga_clk,
  input  logic          vga_reset_n,
  input  logic          vblank,
  input  logic          commit_anytime,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_address,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_strobe,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_address,
  output logic          rsp_valid,
  output logic [31:0]   rsp_data,
  output logic [CW-1:0] pending_count,
  output logic          commit_done,
  output logic [AW-1:0] port_b_address,
  output logic          port_b_rd_en,
  output logic [31:0]   port_b_wr_data,
  output logic [3:0]    port_b_wr_en,
  input  logic [31:0]   port_b_rd_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] fifo_addr   [FIFO_DEPTH];
  logic [31:0]   fifo_data   [FIFO_DEPTH];
  logic [3:0]    fifo_strobe [FIFO_DEPTH];
  logic [PW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          rsp_valid_reg;
  logic          done_reg, done_next;
  logic          gate, full, has_entries, push, pop;

  assign gate        = vblank | commit_anytime;
  assign full        = (count_reg == CW'(FIFO_DEPTH));
  assign has_entries = (count_reg != '0);
  assign wr_ready    = ~vga_reset_n | ~full;
  assign push        = vga_reset_n & wr_valid & ~full;
  assign rd_ready    = rd_valid & vga_reset_n;
  // A read always takes the port; the head write simply waits one cycle.
  assign pop         = vga_reset_n & (state_reg == DRAIN) & gate & has_entries & ~rd_ready;

  always_comb begin
    port_b_address = '0;
    port_b_rd_en   = 1'b0;
    port_b_wr_data = '0;
    port_b_wr_en   = '0;
    if (rd_ready) begin
      port_b_rd_en   = 1'b1;
      port_b_address = rd_address;
    end else if (pop) begin
      port_b_address = fifo_addr[head_reg];
      port_b_wr_data = fifo_data[head_reg];
      port_b_wr_en   = fifo_strobe[head_reg];
    end
  end

  // Queue storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge vga_clk) begin
    if (push) begin
      fifo_addr[tail_reg]   <= wr_address;
      fifo_data[tail_reg]   <= wr_data;
      fifo_strobe[tail_reg] <= wr_strobe;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (has_entries) state_next = gate ? DRAIN : WAIT;
      end
      WAIT: begin
        if (!has_entries)  state_next = IDLE;
        else if (gate)     state_next = DRAIN;
      end
      DRAIN: begin
        if (!gate) begin
          state_next = has_entries ? WAIT : IDLE;
        end else if (pop && count_reg == CW'(1) && !push) begin
          // Last entry leaves with nothing arriving behind it.
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (!has_entries) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (!vga_reset_n) begin
      state_reg     <= IDLE;
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      rsp_valid_reg <= rd_ready;
      done_reg      <= done_next;
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
    end
  end

  assign rsp_valid     = rsp_valid_reg;
  assign rsp_data      = rsp_valid_reg ? port_b_rd_data : '0;
  assign pending_count = count_reg;
  assign commit_done   = done_reg;

endmodule

// File: tb/tb_palette_commit_scheduler.sv
// Bench for palette_commit_scheduler: directed scenarios then random traffic, all checked
// each cycle against a queue-based model of the write backlog and a shadow palette image.
module tb_palette_commit_scheduler;

  localparam int DEPTH = 16;
  localparam int WORDS = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vblank, commit_anytime;
  logic        wr_valid, wr_ready;
  logic [8:0]  wr_address;
  logic [31:0] wr_data;
  logic [3:0]  wr_strobe;
  logic        rd_valid, rd_ready;
  logic [8:0]  rd_address;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  pending_count;
  logic        commit_done;
  logic [8:0]  port_b_address;
  logic        port_b_rd_en;
  logic [31:0] port_b_wr_data;
  logic [3:0]  port_b_wr_en;
  logic [31:0] port_b_rd_data;

  palette_commit_scheduler dut (
    .vga_clk        (clk),
    .vga_reset_n    (rst_n),
    .vblank         (vblank),
    .commit_anytime (commit_anytime),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_address     (wr_address),
    .wr_data        (wr_data),
    .wr_strobe      (wr_strobe),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_address     (rd_address),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .pending_count  (pending_count),
    .commit_done    (commit_done),
    .port_b_address (port_b_address),
    .port_b_rd_en   (port_b_rd_en),
    .port_b_wr_data (port_b_wr_data),
    .port_b_wr_en   (port_b_wr_en),
    .port_b_rd_data (port_b_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Palette RAM behind port B, driven purely by the DUT's port outputs.
  logic        ram_init;
  logic [31:0] ram [WORDS];
  logic [31:0] ram_rd;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= init_word(i);
    end else begin
      if (port_b_rd_en) ram_rd <= ram[port_b_address];
      for (int b = 0; b < 4; b++)
        if (port_b_wr_en[b]) ram[port_b_address][8*b +: 8] <= port_b_wr_data[8*b +: 8];
    end
  end
  assign port_b_rd_data = ram_rd;

  // Reference model
  typedef struct packed {
    logic [8:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t         q[$];
  logic [31:0] ref_mem [WORDS];
  logic        prev_gate, prev_rst, prev_last, prev_rd, last_push;
  int          prev_cnt;
  logic [31:0] prev_rd_data;
  int          wr_seen, done_seen;
  int          checks_total, checks_passed, checks_failed;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks_total++;
    assert (got === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check one cycle's outputs against the model, advance the model across the edge.
  task automatic tick();
    int         cnt;
    logic       gate, rd, issue, push;
    logic [8:0] exp_addr;
    logic [3:0] exp_en;
    wr_t        e;
    #1;
    cnt   = q.size();
    gate  = vblank | commit_anytime;
    rd    = rd_valid & rst_n;
    // Drain engages one cycle after backlog and gate are both seen.
    issue = rst_n && gate && cnt > 0 && !rd && prev_gate && prev_cnt > 0 && prev_rst;
    exp_addr = '0;
    exp_en   = '0;
    if (rd) exp_addr = rd_address;
    else if (issue) begin
      exp_addr = q[0].addr;
      exp_en   = q[0].strb;
    end
    chk("wr_ready", wr_ready, (!rst_n) || (cnt < DEPTH));
    chk("pending_count", pending_count, cnt);
    chk("rd_ready", rd_ready, rd);
    chk("port_b_rd_en", port_b_rd_en, rd);
    chk("port_b_address", port_b_address, exp_addr);
    chk("port_b_wr_en", port_b_wr_en, exp_en);
    if (issue) chk("port_b_wr_data", port_b_wr_data, q[0].data);
    chk("commit_done", commit_done, prev_last);
    chk("rsp_valid", rsp_valid, prev_rd);
    if (prev_rd) chk("rsp_data", rsp_data, prev_rd_data);
    if (port_b_wr_en != 0) wr_seen++;
    if (commit_done) done_seen++;

    push         = rst_n && wr_valid && (cnt < DEPTH);
    last_push    = push;
    prev_rd_data = ref_mem[rd_address];
    if (!rst_n) begin
      q.delete();
      prev_last = 1'b0;
    end else begin
      prev_last = issue && cnt == 1 && !push;
      if (issue) begin
        e = q.pop_front();
        for (int b = 0; b < 4; b++)
          if (e.strb[b]) ref_mem[e.addr][8*b +: 8] = e.data[8*b +: 8];
      end
      if (push) begin
        e.addr = wr_address;
        e.data = wr_data;
        e.strb = wr_strobe;
        q.push_back(e);
      end
    end
    prev_rd   = rd;
    prev_gate = gate;
    prev_cnt  = cnt;
    prev_rst  = rst_n;
    $display("t=%0t rst_n=%0b gate=%0b wr=%0b rd=%0b pend=%0d b_addr=%03h b_wr_en=%h b_rd_en=%0b rsp=%0b done=%0b",
             $time, rst_n, gate, push, rd, cnt, port_b_address, port_b_wr_en, port_b_rd_en, rsp_valid, commit_done);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic queue_write(logic [8:0] a, logic [31:0] d, logic [3:0] s);
    wr_valid   = 1'b1;
    wr_address = a;
    wr_data    = d;
    wr_strobe  = s;
    tick();
    wr_valid   = 1'b0;
  endtask

  initial begin
    int   base_w, base_d, mism;
    logic accepted;

    rst_n = 1'b0; vblank = 1'b0; commit_anytime = 1'b0;
    wr_valid = 1'b0; wr_address = '0; wr_data = '0; wr_strobe = '0;
    rd_valid = 1'b0; rd_address = '0;
    ram_init = 1'b1;
    q.delete();
    prev_gate = 0; prev_rst = 0; prev_last = 0; prev_rd = 0; prev_cnt = 0;
    prev_rd_data = '0; last_push = 0;
    wr_seen = 0; done_seen = 0;
    checks_total = 0; checks_passed = 0; checks_failed = 0;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);

    // 1: three reset cycles, the last one checked
    repeat (2) @(negedge clk);
    ram_init = 1'b0;
    tick();
    chk("reset_wr_ready", wr_ready, 1'b1);
    rst_n = 1'b1;

    // 2: queue outside vblank, then commit in order
    queue_write(9'h004, 32'hA5A5_0F00, 4'b0011);
    queue_write(9'h008, 32'hA5A5_0F00, 4'b0011);
    queue_write(9'h00C, 32'hA5A5_0F00, 4'b0011);
    repeat (2) tick();
    chk("t2_pending", pending_count, 3);
    base_w = wr_seen; base_d = done_seen;
    vblank = 1'b1;
    repeat (6) tick();
    chk("t2_writes", wr_seen - base_w, 3);
    chk("t2_done", done_seen - base_d, 1);
    chk("t2_pending_end", pending_count, 0);

    // 3: fill to capacity, 17th held until a pop
    vblank = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      queue_write(9'h020 + 9'(i), $urandom, 4'($urandom_range(1, 15)));
    wr_valid = 1'b1; wr_address = 9'h1F0; wr_data = $urandom; wr_strobe = 4'hF;
    repeat (3) tick();
    chk("t3_full", wr_ready, 1'b0);
    vblank = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 10 && !accepted; k++) begin
      tick();
      accepted = last_push;
    end
    wr_valid = 1'b0;
    chk("t3_17th_accepted", accepted, 1'b1);
    repeat (22) tick();
    chk("t3_pending_end", pending_count, 0);

    // 4: gate closes after three commits
    vblank = 1'b0;
    for (int i = 0; i < 8; i++)
      queue_write(9'h080 + 9'(4 * i), $urandom, 4'($urandom_range(1, 15)));
    base_w = wr_seen; base_d = done_seen;
    vblank = 1'b1;
    for (int k = 0; k < 12 && (wr_seen - base_w) < 3; k++) tick();
    vblank = 1'b0;
    repeat (4) tick();
    chk("t4_writes_partial", wr_seen - base_w, 3);
    chk("t4_pending_partial", pending_count, 5);
    chk("t4_no_done", done_seen - base_d, 0);
    vblank = 1'b1;
    repeat (8) tick();
    chk("t4_writes_all", wr_seen - base_w, 8);
    chk("t4_done", done_seen - base_d, 1);

    // 5: read pre-empts a drain; queued write to the same word is not forwarded
    vblank = 1'b0;
    queue_write(9'h100, $urandom, 4'hF);
    queue_write(9'h104, $urandom, 4'hF);
    queue_write(9'h108, $urandom, 4'hF);
    queue_write(9'h010, 32'hDEAD_BEEF, 4'hF);
    vblank = 1'b1;
    repeat (2) tick();
    rd_valid = 1'b1; rd_address = 9'h010;
    tick();
    rd_valid = 1'b0;
    repeat (6) tick();

    // 6: reset mid-drain discards the backlog
    vblank = 1'b0;
    for (int i = 0; i < 6; i++)
      queue_write(9'h140 + 9'(4 * i), $urandom, 4'($urandom_range(1, 15)));
    vblank = 1'b1;
    repeat (3) tick();
    chk("t6_pending_before", pending_count, 4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    base_w = wr_seen;
    repeat (5) tick();
    chk("t6_pending_after", pending_count, 0);
    chk("t6_no_writes", wr_seen - base_w, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) vblank = ~vblank;
      commit_anytime = ($urandom_range(0, 15) == 0);
      wr_valid   = $urandom_range(0, 1) == 1;
      wr_address = 9'($urandom);
      wr_data    = $urandom;
      wr_strobe  = 4'($urandom_range(0, 15));
      rd_valid   = ($urandom_range(0, 3) == 0);
      rd_address = 9'($urandom);
      rst_n      = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0;
    commit_anytime = 1'b0; vblank = 1'b1;
    repeat (25) tick();
    chk("final_pending", pending_count, 0);

    mism = 0;
    for (int i = 0; i < WORDS; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk("ram_image", mism, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
